// File: rtl/fft_pkg.sv
// Shared definitions for the FFT datapath: magnitude mode encoding and
// width helpers used by the FFT core and its post-processing blocks.
package fft_pkg;

  // Magnitude estimate selector; the reserved code falls back to power.
  typedef enum logic [1:0] {
    MAG_PWR  = 2'd0,
    MAG_L1   = 2'd1,
    MAG_AMBM = 2'd2,
    MAG_RSVD = 2'd3
  } mag_mode_e;

  // Ceiling log2, with a floor of 1 bit for tiny values.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

  // Full-precision magnitude width: the power estimate needs twice the input width.
  function automatic int mag_width(input int in_w);
    return 2 * in_w;
  endfunction

endpackage

// File: rtl/fft_mag_calc.sv
// Combinational magnitude estimate for one bin: power, L1 or alpha-max-beta-min,
// followed by the mode-dependent right shift and saturation to the output width.
module fft_mag_calc
  import fft_pkg::*;
#(
  parameter int IN_W      = 12,
  parameter int OUT_W     = 8,
  parameter int PWR_SHIFT = 16,
  parameter int LIN_SHIFT = 5,
  localparam int MAG_W    = mag_width(IN_W)
) (
  input  logic [IN_W-1:0]  abs_re,
  input  logic [IN_W-1:0]  abs_im,
  input  mag_mode_e        mode,
  output logic [MAG_W-1:0] mag_full,
  output logic [OUT_W-1:0] mag_sat
);

  logic [MAG_W-1:0] ext_re;
  logic [MAG_W-1:0] ext_im;
  logic [IN_W-1:0]  larger;
  logic [IN_W-1:0]  smaller;
  logic [IN_W:0]    lin;
  logic [MAG_W-1:0] shifted;

  // Pick the estimate for the mode, then scale and clamp to all-ones on overflow.
  always_comb begin
    ext_re   = MAG_W'(abs_re);
    ext_im   = MAG_W'(abs_im);
    larger   = (abs_re > abs_im) ? abs_re : abs_im;
    smaller  = (abs_re > abs_im) ? abs_im : abs_re;
    lin      = '0;
    mag_full = '0;
    shifted  = '0;
    mag_sat  = '0;
    case (mode)
      MAG_L1: begin
        lin      = {1'b0, abs_re} + {1'b0, abs_im};
        mag_full = MAG_W'(lin);
        shifted  = mag_full >> LIN_SHIFT;
      end
      MAG_AMBM: begin
        lin      = {1'b0, larger} + {1'b0, smaller >> 1};
        mag_full = MAG_W'(lin);
        shifted  = mag_full >> LIN_SHIFT;
      end
      default: begin
        mag_full = ext_re * ext_re + ext_im * ext_im;
        shifted  = mag_full >> PWR_SHIFT;
      end
    endcase
    if (|shifted[MAG_W-1:OUT_W]) mag_sat = '1;
    else                         mag_sat = shifted[OUT_W-1:0];
  end

endmodule

// File: rtl/fft_mag_stream.sv
// Streaming magnitude post-processor: two-register back-pressured pipeline
// (abs stage, then magnitude/scale into the output register) with per-frame
// peak-bin tracking on the full-precision magnitude.
module fft_mag_stream
  import fft_pkg::*;
#(
  parameter int IN_W         = 12,
  parameter int OUT_W        = 8,
  parameter int N_BINS       = 8,
  parameter int PWR_SHIFT    = 16,
  parameter int LIN_SHIFT    = 5,
  parameter int PEAK_SKIP_DC = 1,
  localparam int BIN_W       = clog2(N_BINS),
  localparam int MAG_W       = mag_width(IN_W)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             mode,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic signed [IN_W-1:0] s_re,
  input  logic signed [IN_W-1:0] s_im,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [OUT_W-1:0]       m_mag,
  output logic [BIN_W-1:0]       m_bin,
  output logic                   m_last,
  output logic                   peak_valid,
  output logic [BIN_W-1:0]       peak_bin,
  output logic [OUT_W-1:0]       peak_mag
);

  localparam logic [BIN_W-1:0] LAST_BIN  = BIN_W'(N_BINS - 1);
  localparam logic [BIN_W-1:0] FIRST_BIN = BIN_W'((PEAK_SKIP_DC != 0) ? 1 : 0);

  logic [BIN_W-1:0] in_bin_q, in_bin_d;
  mag_mode_e        frame_mode_q, frame_mode_d;
  logic             v1_q, v1_d;
  logic [IN_W-1:0]  are1_q, are1_d, aim1_q, aim1_d;
  logic [BIN_W-1:0] bin1_q, bin1_d;
  mag_mode_e        mode1_q, mode1_d;
  logic             v2_q, v2_d;
  logic [OUT_W-1:0] mag2_q, mag2_d;
  logic [BIN_W-1:0] bin2_q, bin2_d;
  logic             last2_q, last2_d;
  logic [MAG_W-1:0] run_full_q, run_full_d;
  logic [OUT_W-1:0] run_sat_q, run_sat_d;
  logic [BIN_W-1:0] run_bin_q, run_bin_d;
  logic             peak_valid_q, peak_valid_d;
  logic [BIN_W-1:0] peak_bin_q, peak_bin_d;
  logic [OUT_W-1:0] peak_mag_q, peak_mag_d;

  logic             free1, free2, s_fire, load2, take;
  logic [MAG_W-1:0] calc_full;
  logic [OUT_W-1:0] calc_sat;

  fft_mag_calc #(
    .IN_W      (IN_W),
    .OUT_W     (OUT_W),
    .PWR_SHIFT (PWR_SHIFT),
    .LIN_SHIFT (LIN_SHIFT)
  ) u_calc (
    .abs_re   (are1_q),
    .abs_im   (aim1_q),
    .mode     (mode1_q),
    .mag_full (calc_full),
    .mag_sat  (calc_sat)
  );

  // Handshake: a stage may load when empty or when the stage after it drains.
  always_comb begin
    free2   = !v2_q || m_ready;
    free1   = !v1_q || free2;
    s_ready = !rst && free1;
    s_fire  = s_valid && s_ready;
    load2   = free2 && v1_q;
  end

  // Next-state for bin counter, frame mode, both pipeline stages and peak tracking.
  always_comb begin
    in_bin_d     = in_bin_q;
    frame_mode_d = frame_mode_q;
    v1_d         = free1 ? s_fire : v1_q;
    are1_d       = are1_q;
    aim1_d       = aim1_q;
    bin1_d       = bin1_q;
    mode1_d      = mode1_q;
    v2_d         = free2 ? v1_q : v2_q;
    mag2_d       = mag2_q;
    bin2_d       = bin2_q;
    last2_d      = last2_q;
    run_full_d   = run_full_q;
    run_sat_d    = run_sat_q;
    run_bin_d    = run_bin_q;
    peak_valid_d = 1'b0;
    peak_bin_d   = peak_bin_q;
    peak_mag_d   = peak_mag_q;
    take         = (bin1_q == FIRST_BIN) ||
                   ((bin1_q > FIRST_BIN) && (calc_full > run_full_q));

    if (s_fire) begin
      in_bin_d = (in_bin_q == LAST_BIN) ? '0 : in_bin_q + 1'b1;
      are1_d   = s_re[IN_W-1] ? (~s_re + 1'b1) : s_re;
      aim1_d   = s_im[IN_W-1] ? (~s_im + 1'b1) : s_im;
      bin1_d   = in_bin_q;
      if (in_bin_q == '0) begin
        frame_mode_d = mag_mode_e'(mode);
        mode1_d      = mag_mode_e'(mode);
      end else begin
        mode1_d      = frame_mode_q;
      end
    end

    if (load2) begin
      mag2_d  = calc_sat;
      bin2_d  = bin1_q;
      last2_d = (bin1_q == LAST_BIN);
      if (take) begin
        run_full_d = calc_full;
        run_sat_d  = calc_sat;
        run_bin_d  = bin1_q;
      end
      if (bin1_q == LAST_BIN) begin
        peak_valid_d = 1'b1;
        peak_bin_d   = take ? bin1_q : run_bin_q;
        peak_mag_d   = take ? calc_sat : run_sat_q;
      end
    end
  end

  // State registers with synchronous reset that drops any partial frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_bin_q     <= '0;
      frame_mode_q <= MAG_PWR;
      v1_q         <= 1'b0;
      are1_q       <= '0;
      aim1_q       <= '0;
      bin1_q       <= '0;
      mode1_q      <= MAG_PWR;
      v2_q         <= 1'b0;
      mag2_q       <= '0;
      bin2_q       <= '0;
      last2_q      <= 1'b0;
      run_full_q   <= '0;
      run_sat_q    <= '0;
      run_bin_q    <= '0;
      peak_valid_q <= 1'b0;
      peak_bin_q   <= '0;
      peak_mag_q   <= '0;
    end else begin
      in_bin_q     <= in_bin_d;
      frame_mode_q <= frame_mode_d;
      v1_q         <= v1_d;
      are1_q       <= are1_d;
      aim1_q       <= aim1_d;
      bin1_q       <= bin1_d;
      mode1_q      <= mode1_d;
      v2_q         <= v2_d;
      mag2_q       <= mag2_d;
      bin2_q       <= bin2_d;
      last2_q      <= last2_d;
      run_full_q   <= run_full_d;
      run_sat_q    <= run_sat_d;
      run_bin_q    <= run_bin_d;
      peak_valid_q <= peak_valid_d;
      peak_bin_q   <= peak_bin_d;
      peak_mag_q   <= peak_mag_d;
    end
  end

  assign m_valid    = v2_q;
  assign m_mag      = mag2_q;
  assign m_bin      = bin2_q;
  assign m_last     = last2_q;
  assign peak_valid = peak_valid_q;
  assign peak_bin   = peak_bin_q;
  assign peak_mag   = peak_mag_q;

endmodule
